// File: rtl/rv32i_ex_unit_pkg.sv
// Shared types and constants for the RV32I execute slice.
// Holds the control word, ALU op encoding and the opcode/funct3 values used by decode.
package rv32i_ex_unit_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    use_imm;
    logic    is_branch;
    alu_op_e alu_op;
  } ctrl_t;

  // funct3 is shared by R- and I-type; alt (inst[30]) picks SUB/SRA where allowed.
  function automatic alu_op_e decode_alu_op(input logic [2:0] funct3,
                                            input logic       alt,
                                            input logic       allow_sub);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32i_ex_unit_if.sv
// Execute-stage bus: instruction/operands in, regfile addresses and registered results out.
// slave = execute unit, master = the surrounding pipeline.
interface rv32i_ex_unit_if;
  import rv32i_ex_unit_pkg::*;

  logic [31:0]     inst;
  logic [31:0]     pc;
  logic            flush;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [XLEN-1:0] rs1_value;
  logic [XLEN-1:0] rs2_value;
  logic [XLEN-1:0] wb_result;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic            branch_taken;
  logic [31:0]     branch_target;

  modport slave (
    input  inst, pc, flush, rs1_value, rs2_value,
    output rs1, rs2, wb_result, wb_rd, wb_we, branch_taken, branch_target
  );

  modport master (
    output inst, pc, flush, rs1_value, rs2_value,
    input  rs1, rs2, wb_result, wb_rd, wb_we, branch_taken, branch_target
  );
endinterface

// File: rtl/rv32i_ex_unit_alu.sv
// RV32I integer ALU, purely combinational; shifts use b[4:0], results wrap.
// No state, no backpressure.
module rv32i_alu_core
  import rv32i_ex_unit_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = a + b;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << shamt;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> shamt;
      ALU_SRA:  y = $signed(a) >>> shamt;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/rv32i_ex_unit.sv
// Execute slice: inline decode + I/B immediates + ALU + BEQ compare, one registered cycle.
// rs1/rs2 are combinational; flush loads a bubble, reset wins over flush; no backpressure.
module rv32i_ex_unit
  import rv32i_ex_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  rv32i_ex_unit_if.slave   bus
);

  ctrl_t           ctrl;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     imm_i;
  logic [31:0]     imm_b;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;

  assign opcode  = bus.inst[6:0];
  assign funct3  = bus.inst[14:12];
  assign bus.rs1 = bus.inst[19:15];
  assign bus.rs2 = bus.inst[24:20];

  assign imm_i = {{20{bus.inst[31]}}, bus.inst[31:20]};
  assign imm_b = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                  bus.inst[30:25], bus.inst[11:8], 1'b0};

  // Unknown opcodes/funct3 leave every control bit low so the slot is a bubble.
  always_comb begin
    ctrl = '{reg_write: 1'b0, use_imm: 1'b0, is_branch: 1'b0, alu_op: ALU_ADD};
    case (opcode)
      OPC_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = decode_alu_op(funct3, bus.inst[30], 1'b1);
      end
      OPC_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.alu_op    = decode_alu_op(funct3, bus.inst[30], 1'b0);
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ) begin
          ctrl.is_branch = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign alu_b = ctrl.use_imm ? imm_i : bus.rs2_value;

  rv32i_alu_core u_alu (
    .a  (bus.rs1_value),
    .b  (alu_b),
    .op (ctrl.alu_op),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush) begin
      bus.wb_result     <= '0;
      bus.wb_rd         <= '0;
      bus.wb_we         <= 1'b0;
      bus.branch_taken  <= 1'b0;
      bus.branch_target <= '0;
    end else begin
      bus.wb_result     <= alu_y;
      bus.wb_rd         <= bus.inst[11:7];
      bus.wb_we         <= ctrl.reg_write;
      bus.branch_taken  <= ctrl.is_branch && (bus.rs1_value == bus.rs2_value);
      bus.branch_target <= bus.pc + imm_b;
    end
  end

endmodule

// File: tb/tb_rv32i_ex_unit.sv
// Directed-vector bench for rv32i_ex_unit with hand-computed expectations.
module tb_rv32i_ex_unit;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

  rv32i_ex_unit_if bus ();

  rv32i_ex_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    bus.inst      = i;
    bus.pc        = p;
    bus.rs1_value = a;
    bus.rs2_value = b;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    bus.flush   = 1'b0;
    drive(32'h0050_0093, 32'h0, 32'h0, 32'h0);

    // Reset held over two edges
    cycle();
    cycle();
    chk("rst_result", bus.wb_result, 32'h0);
    chk("rst_rd",     32'(bus.wb_rd), 32'h0);
    chk("rst_we",     32'(bus.wb_we), 32'h0);
    chk("rst_taken",  32'(bus.branch_taken), 32'h0);
    chk("rst_target", bus.branch_target, 32'h0);

    // addi x1,x0,5 after release; its B-immediate bits give 0x800
    reset_n = 1'b1;
    cycle();
    chk("addi_result", bus.wb_result, 32'd5);
    chk("addi_rd",     32'(bus.wb_rd), 32'd1);
    chk("addi_we",     32'(bus.wb_we), 32'd1);
    chk("addi_taken",  32'(bus.branch_taken), 32'd0);
    chk("addi_target", bus.branch_target, 32'h800);

    // addi x1,x0,-1: sign-extended immediate
    drive(32'hFFF0_0093, 32'h0, 32'h0, 32'h0);
    cycle();
    chk("addi_neg_result", bus.wb_result, 32'hFFFF_FFFF);
    chk("addi_neg_we",     32'(bus.wb_we), 32'd1);

    // add x3,x1,x2 and combinational regfile addresses
    drive(32'h0020_81B3, 32'h0, 32'd5, 32'd7);
    #1;
    chk("rs1_addr", 32'(bus.rs1), 32'd1);
    chk("rs2_addr", 32'(bus.rs2), 32'd2);
    cycle();
    chk("add_result", bus.wb_result, 32'd12);
    chk("add_rd",     32'(bus.wb_rd), 32'd3);

    drive(32'h4020_81B3, 32'h0, 32'd5, 32'd7);
    cycle();
    chk("sub_result", bus.wb_result, 32'hFFFF_FFFE);

    // slt / sltu with -1 vs 1
    drive(32'h0020_A1B3, 32'h0, 32'hFFFF_FFFF, 32'd1);
    cycle();
    chk("slt_result", bus.wb_result, 32'd1);
    drive(32'h0020_B1B3, 32'h0, 32'hFFFF_FFFF, 32'd1);
    cycle();
    chk("sltu_result", bus.wb_result, 32'd0);

    // sll uses only rs2[4:0]: 0x21 shifts by 1
    drive(32'h0020_91B3, 32'h0, 32'd3, 32'h21);
    cycle();
    chk("sll_result", bus.wb_result, 32'd6);

    // srai x5,x1,4
    drive(32'h4040_D293, 32'h0, 32'h8000_0000, 32'h0);
    cycle();
    chk("srai_result", bus.wb_result, 32'hF800_0000);
    chk("srai_rd",     32'(bus.wb_rd), 32'd5);

    // beq x1,x2,+8 at pc 0x10
    drive(32'h0020_8463, 32'h10, 32'd9, 32'd9);
    cycle();
    chk("beq_eq_taken",  32'(bus.branch_taken), 32'd1);
    chk("beq_eq_target", bus.branch_target, 32'h18);
    chk("beq_eq_we",     32'(bus.wb_we), 32'd0);

    drive(32'h0020_8463, 32'h10, 32'd9, 32'd8);
    cycle();
    chk("beq_ne_taken",  32'(bus.branch_taken), 32'd0);
    chk("beq_ne_target", bus.branch_target, 32'h18);

    // beq x1,x2,-4 at pc 0x10: negative B-immediate
    drive(32'hFE20_8EE3, 32'h10, 32'd9, 32'd9);
    cycle();
    chk("beq_back_taken",  32'(bus.branch_taken), 32'd1);
    chk("beq_back_target", bus.branch_target, 32'h0C);

    // bne is not decoded: bubble even with equal operands
    drive(32'h0020_9463, 32'h10, 32'd9, 32'd9);
    cycle();
    chk("bne_taken", 32'(bus.branch_taken), 32'd0);
    chk("bne_we",    32'(bus.wb_we), 32'd0);

    // flush forces an all-zero bubble
    drive(32'h0050_0093, 32'h10, 32'd0, 32'd0);
    bus.flush = 1'b1;
    cycle();
    chk("flush_we",     32'(bus.wb_we), 32'd0);
    chk("flush_taken",  32'(bus.branch_taken), 32'd0);
    chk("flush_result", bus.wb_result, 32'd0);
    chk("flush_rd",     32'(bus.wb_rd), 32'd0);
    chk("flush_target", bus.branch_target, 32'd0);
    bus.flush = 1'b0;

    // illegal opcode
    drive(32'h0000_007F, 32'h0, 32'd0, 32'd0);
    cycle();
    chk("illegal_we",    32'(bus.wb_we), 32'd0);
    chk("illegal_taken", 32'(bus.branch_taken), 32'd0);

    // mid-stream reset clears on the same edge
    drive(32'h0050_0093, 32'h0, 32'd0, 32'd0);
    cycle();
    chk("pre_rst_we", 32'(bus.wb_we), 32'd1);
    reset_n = 1'b0;
    cycle();
    chk("mid_rst_we",     32'(bus.wb_we), 32'd0);
    chk("mid_rst_result", bus.wb_result, 32'd0);
    chk("mid_rst_rd",     32'(bus.wb_rd), 32'd0);
    chk("mid_rst_target", bus.branch_target, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv32i_ex_unit.md
Name: rv32i_ex_unit

Overview:
Execute-stage datapath slice for the 3-stage RV32I core: decodes one instruction, generates I/B immediates, runs the ALU and resolves BEQ. Regfile read addresses are combinational; all results are registered for one cycle before going to writeback and PC-redirect logic. The block replaces the loose decoder/imm_gen/alu trio with one registered unit.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous, active-low reset
inst  input  32  instruction in EX
pc  input  32  PC of inst
flush  input  1  force bubble into the output register this cycle
rs1  output  5  inst[19:15], combinational (regfile raddr1)
rs2  output  5  inst[24:20], combinational (regfile raddr2)
rs1_value  input  32  forwarded rs1 operand
rs2_value  input  32  forwarded rs2 operand
wb_result  output  32  registered ALU result
wb_rd  output  5  registered destination, inst[11:7]
wb_we  output  1  registered reg-write enable
branch_taken  output  1  registered: BEQ and rs1_value==rs2_value
branch_target  output  32  registered pc + imm_b

Behaviour:
- Clock is clk; reset is synchronous, active-low (reset_n); one clock domain.
- Reset: on a clk edge with reset_n=0, every registered output is 0 (wb_we=0, branch_taken=0). rs1/rs2 stay combinational.
- Latency: one cycle. Outputs after edge N reflect the inst, pc and operands sampled at edge N.
- flush=1 (reset_n=1): outputs load a bubble: wb_we=0, branch_taken=0, other outputs 0. Reset has priority over flush.
- Decode (opcode inst[6:0]):
  - 0110011 R-type: reg_write=1, use_imm=0. ALU op from funct3/funct7[5]: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - 0010011 I-type: reg_write=1, use_imm=1. ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI. SRAI vs SRLI is selected by inst[30].
  - 1100011 with funct3=000 (BEQ): is_branch=1, reg_write=0.
  - Any other opcode or funct3: all controls 0, so the slot acts as a bubble.
- rd=0: wb_we follows decode, but wb_result is still driven. Downstream logic ignores writes to x0.
- imm_i = sign-extend inst[31:20].
- imm_b = sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
- ALU operands: a = rs1_value; b = use_imm ? imm_i : rs2_value.
- ALU arithmetic: 32-bit, wraps on overflow. Shifts use b[4:0]. SLT is signed and SLTU unsigned; both give 0 or 1.
- For a branch, wb_result is the ALU ADD result and is don't-care to consumers.
- Branch: branch_taken = is_branch && (rs1_value == rs2_value). branch_target = pc + imm_b (wrapping) and is registered every cycle regardless of taken.

Decomposition:
- types_pkg holds:
  - alu_op_e enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - ctrl_t struct: reg_write, use_imm, is_branch, alu_op.
  - Opcode localparams and NOP_INST.
- Decoder and imm_gen logic stay inline.
- One combinational sub-module rv32i_alu_core (a, b, op -> y) is natural.

Test Plan:
- Reset: hold reset_n=0 for 2 edges with inst=0x00500093 -> all registered outputs 0. Release -> next edge wb_result=5, wb_rd=1, wb_we=1.
- I-type sign extension: inst=0xFFF00093, rs1_value=0 -> wb_result=0xFFFFFFFF, wb_we=1.
- R-type ADD/SUB: rs1_value=5, rs2_value=7.
  - 0x002081B3 -> wb_result=12, wb_rd=3.
  - 0x402081B3 -> wb_result=0xFFFFFFFE.
- SRAI: inst=0x4040D293, rs1_value=0x80000000 -> wb_result=0xF8000000, wb_rd=5.
- BEQ: inst=0x00208463, pc=0x10.
  - Equal operands (9,9) -> branch_taken=1, branch_target=0x18, wb_we=0.
  - Operands 9,8 -> branch_taken=0, branch_target=0x18.
- Flush and illegal opcode:
  - flush=1 with 0x00500093 -> wb_we=0, branch_taken=0.
  - inst=0x0000007F -> wb_we=0, branch_taken=0.
  - Mid-stream reset_n=0 -> outputs 0 on that same edge.
